// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Clocked stimulus generator and checker for a small combinational function block.
// It steps through every input combination in ascending order and samples the
// block's response for each one. The captured truth table is compared against
// EXPECTED, and a pass flag plus a one-cycle done pulse are raised at the end.
// All outputs are registered.

module truth_table_sweeper #(
    parameter int                        N_IN       = 3,
    parameter int                        SETTLE_CYC = 1,
    parameter logic [(1 << N_IN) - 1:0]  EXPECTED   = 8'h71
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        s_in,
    output logic [N_IN-1:0]             vec_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [(1 << N_IN) - 1:0]    captured,
    output logic [(1 << N_IN) - 1:0]    mismatch,
    output logic [N_IN:0]               err_count
);

    // Number of vectors in one sweep.
    localparam int NVEC = 1 << N_IN;

    // Settle counter width; a zero-settle build still gets a 1-bit counter.
    localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC);
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NVEC - 1);

    // With no settle time the sweep goes straight from one sample to the next.
    localparam logic            SKIP_SETTLE = (SETTLE_CYC == 0) ? 1'b1 : 1'b0;

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]      state_r;
    logic [1:0]      state_next_s;
    logic [N_IN-1:0] idx_r;
    logic [CW-1:0]   cnt_r;

    logic            sample_one_s;
    logic            sample_zero_s;
    logic            exp_bit_s;
    logic            miss_s;
    logic            last_s;

    // Count the set bits of a mismatch vector. Kept as a reference for the
    // running counter, which must always equal the popcount of mismatch.
    function automatic logic [N_IN:0] popcount(input logic [NVEC-1:0] v);
        logic [N_IN:0] acc;
        acc = {(N_IN + 1){1'b0}};
        for (int i = 0; i < NVEC; i++) begin
            acc = acc + {{N_IN{1'b0}}, v[i]};
        end
        return acc;
    endfunction

    // Classify the current response. x or z never counts as a valid 0 or 1.
    always_comb begin
        sample_one_s  = (s_in === 1'b1);
        sample_zero_s = (s_in === 1'b0);
        exp_bit_s     = EXPECTED[idx_r];
        if (exp_bit_s) begin
            miss_s = ~sample_one_s;
        end else begin
            miss_s = ~sample_zero_s;
        end
        last_s = (idx_r == LAST_IDX);
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (SKIP_SETTLE) begin
                        state_next_s = ST_SAMPLE;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // The counter reaches 0 on this cycle's decrement.
                if (cnt_r <= CW'(1)) begin
                    state_next_s = ST_SAMPLE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else if (SKIP_SETTLE) begin
                    state_next_s = ST_SAMPLE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: vector index, settle timer, results and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r     <= {N_IN{1'b0}};
            cnt_r     <= {CW{1'b0}};
            vec_out   <= {N_IN{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            captured  <= {NVEC{1'b0}};
            mismatch  <= {NVEC{1'b0}};
            err_count <= {(N_IN + 1){1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_r     <= {N_IN{1'b0}};
                        vec_out   <= {N_IN{1'b0}};
                        cnt_r     <= SETTLE_LOAD;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        captured  <= {NVEC{1'b0}};
                        mismatch  <= {NVEC{1'b0}};
                        err_count <= {(N_IN + 1){1'b0}};
                    end
                end
                ST_SETTLE: begin
                    cnt_r <= cnt_r - CW'(1);
                end
                ST_SAMPLE: begin
                    captured[idx_r] <= sample_one_s;
                    mismatch[idx_r] <= miss_s;
                    // Each index is sampled once per sweep, so the count
                    // cannot exceed NVEC and never wraps.
                    err_count <= err_count + {{N_IN{1'b0}}, miss_s};
                    if (last_s) begin
                        busy <= 1'b0;
                    end else begin
                        idx_r   <= idx_r + N_IN'(1);
                        vec_out <= idx_r + N_IN'(1);
                        cnt_r   <= SETTLE_LOAD;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                    pass <= (err_count == {(N_IN + 1){1'b0}});
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // Debug view of the running error count derived from the mismatch map.
    logic [N_IN:0] err_ref_s;
    always_comb begin
        err_ref_s = popcount(mismatch);
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// A behavioural model of the function block drives s_in from vec_out. The
// expected captured/mismatch/err_count/pass values are computed from the
// stimulus table with plain loops. Sweep timing is checked by counting clock
// edges from the accepting edge.

module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       s_in;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [7:0] mismatch;
    logic [3:0] err_count;

    // Second instance: zero settle time
    logic       start0;
    logic       s_in0;
    logic [2:0] vec_out0;
    logic       busy0;
    logic       done0;
    logic       pass0;
    logic [7:0] captured0;
    logic [7:0] mismatch0;
    logic [3:0] err_count0;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_tbl;
    logic       x_val;
    int         mode;
    logic [7:0] tbl;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(1), .EXPECTED(8'h71)) dut (
        .clk(clk), .reset(reset), .start(start), .s_in(s_in),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch(mismatch), .err_count(err_count)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(0), .EXPECTED(8'h71)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .s_in(s_in0),
        .vec_out(vec_out0), .busy(busy0), .done(done0), .pass(pass0),
        .captured(captured0), .mismatch(mismatch0), .err_count(err_count0)
    );

    // Function block model: 0 golden, 1 inverted, 2 unknown, else table.
    function automatic logic blk_val(input int m, input logic [7:0] t, input int i);
        case (m)
            0:       return exp_tbl[i];
            1:       return ~exp_tbl[i];
            2:       return x_val;
            default: return t[i];
        endcase
    endfunction

    always_comb s_in  = blk_val(mode, tbl, int'(vec_out));
    always_comb s_in0 = exp_tbl[vec_out0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"},
                  {13'd0, vec_out, busy, done, pass, captured, mismatch, err_count},
                  32'd0);
    endtask

    // One start pulse, then follow the sweep edge by edge.
    task automatic run_sweep(input int m, input logic [7:0] t, input string tag);
        logic [7:0] ecap;
        logic [7:0] emis;
        int         eerr;
        int         lat;
        int         vec_err;
        logic       v;
        ecap = 8'd0;
        emis = 8'd0;
        eerr = 0;
        for (int i = 0; i < 8; i++) begin
            v       = blk_val(m, t, i);
            ecap[i] = (v === 1'b1);
            emis[i] = (v !== exp_tbl[i]);
            if (emis[i]) eerr++;
        end
        mode = m;
        tbl  = t;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        lat     = -1;
        vec_err = (vec_out !== 3'd0) ? 1 : 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k < 16 && vec_out !== 3'(k / 2)) vec_err++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_val({tag, "_latency"}, lat, 17);
        check_val({tag, "_vec_seq"}, vec_err, 0);
        check_val({tag, "_captured"}, {24'd0, captured}, {24'd0, ecap});
        check_val({tag, "_mismatch"}, {24'd0, mismatch}, {24'd0, emis});
        check_val({tag, "_err_count"}, {28'd0, err_count}, eerr);
        check_val({tag, "_pass"}, {31'd0, pass}, (eerr == 0) ? 32'd1 : 32'd0);
        check_val({tag, "_vec_last"}, {29'd0, vec_out}, 32'd7);
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, "_hold_cap"}, {24'd0, captured}, {24'd0, ecap});
    endtask

    initial begin
        int   found;
        int   first_done;
        int   second_done;
        logic busy_after;
        exp_tbl = 8'h71;
        x_val   = 1'bx;
        mode    = 0;
        tbl     = 8'd0;

        // 1: reset with start asserted
        reset  = 1'b1;
        start  = 1'b1;
        start0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_val("reset_dut0", {27'd0, vec_out0, busy0, done0}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("no_sweep_after_reset", {28'd0, vec_out, busy}, 32'd0);

        // 2: golden sweep
        run_sweep(0, 8'd0, "golden");
        // 3: inverted block
        run_sweep(1, 8'd0, "inverted");
        // 4: unknown output, then golden rerun
        run_sweep(2, 8'd0, "xval");
        run_sweep(0, 8'd0, "golden_rerun");

        // Random truth tables with random idle gaps
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(3, 8'($urandom), "random");
        end

        // 5: reset mid-sweep while vector 4 is applied
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (vec_out === 3'b100) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_val("mid_reset_reach_vec4", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_val("mid_reset_no_done", {30'd0, done, busy}, 32'd0);
        run_sweep(0, 8'd0, "after_reset");

        // 6: start held high, back-to-back sweeps (SETTLE_CYC=1)
        @(negedge clk);
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        busy_after  = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (k == first_done + 1 && first_done > 0) busy_after = busy;
            if (done) begin
                if (first_done < 0) begin
                    first_done = k;
                end else begin
                    second_done = k;
                    break;
                end
            end
        end
        start = 1'b0;
        check_val("b2b_first_done", first_done, 17);
        check_val("b2b_rearm_busy", {31'd0, busy_after}, 32'd1);
        check_val("b2b_second_done", second_done, 35);
        check_val("b2b_pass", {31'd0, pass}, 32'd1);

        // 6: SETTLE_CYC=0 build, start held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        start0      = 1'b1;
        first_done  = -1;
        second_done = -1;
        busy_after  = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == first_done + 1 && first_done > 0) busy_after = busy0;
            if (done0) begin
                if (first_done < 0) begin
                    first_done = k;
                    check_val("s0_busy_at_done", {31'd0, busy0}, 32'd0);
                end else begin
                    second_done = k;
                    break;
                end
            end
        end
        start0 = 1'b0;
        check_val("s0_first_done", first_done, 9);
        check_val("s0_rearm_busy", {31'd0, busy_after}, 32'd1);
        check_val("s0_second_done", second_done, 19);
        check_val("s0_captured", {24'd0, captured0}, 32'h71);
        check_val("s0_result", {27'd0, pass0, err_count0}, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
